// File: rtl/poly_ctrl_s_axi_if.sv
// AXI4-Lite channel bundle for the poly control slave.
// Data is fixed at 32 bits with a 4-bit byte strobe.
interface poly_ctrl_s_axi_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/poly_ctrl_s_axi.sv
// AXI4-Lite control slave: ap_ctrl block, interrupt controller, NUM_ARGS
// argument registers and a clear-on-read result register.
module poly_ctrl_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_ARGS           = 3,
    parameter int ARG_WIDTH          = 32,
    parameter int RES_WIDTH          = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ACLK_EN,
    poly_ctrl_s_axi_if.slave              s_axi,
    output logic                          ap_start,
    input  logic                          ap_done,
    input  logic                          ap_idle,
    input  logic                          ap_ready,
    output logic [NUM_ARGS*ARG_WIDTH-1:0] args,
    input  logic [RES_WIDTH-1:0]          res_data,
    input  logic                          res_vld,
    output logic                          interrupt
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTRL = AW'(0);
    localparam logic [AW-1:0] A_GIE  = AW'(4);
    localparam logic [AW-1:0] A_IER  = AW'(8);
    localparam logic [AW-1:0] A_ISR  = AW'(12);
    localparam logic [AW-1:0] A_RES  = AW'(16 + 8*NUM_ARGS);
    localparam logic [AW-1:0] A_RVLD = AW'(20 + 8*NUM_ARGS);

    typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_e;
    typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [AW-1:0]                 waddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, wmask;
    logic                          start_q, done_q, auto_q, gie_q, irq_q, rvld_q;
    logic [1:0]                    ier_q, isr_q;
    logic [RES_WIDTH-1:0]          res_q;
    logic [NUM_ARGS-1:0][ARG_WIDTH-1:0] args_q, args_d;
    logic [NUM_ARGS-1:0][63:0]          arg_pad;
    logic aw_hs, w_hs, ar_hs, wr_ctrl, wr_isr;

    assign aw_hs   = s_axi.AWVALID & s_axi.AWREADY;
    assign w_hs    = s_axi.WVALID & s_axi.WREADY;
    assign ar_hs   = s_axi.ARVALID & s_axi.ARREADY;
    assign wr_ctrl = w_hs && waddr_q == A_CTRL && s_axi.WSTRB[0];
    assign wr_isr  = w_hs && waddr_q == A_ISR && s_axi.WSTRB[0];
    assign wmask   = {{8{s_axi.WSTRB[3]}}, {8{s_axi.WSTRB[2]}},
                      {8{s_axi.WSTRB[1]}}, {8{s_axi.WSTRB[0]}}};

    assign s_axi.AWREADY = (wstate_q == WRIDLE);
    assign s_axi.WREADY  = (wstate_q == WRDATA);
    assign s_axi.BVALID  = (wstate_q == WRRESP);
    assign s_axi.BRESP   = 2'b00;
    assign s_axi.ARREADY = (rstate_q == RDIDLE);
    assign s_axi.RVALID  = (rstate_q == RDDATA);
    assign s_axi.RRESP   = 2'b00;
    assign s_axi.RDATA   = rdata_q;

    assign ap_start  = start_q;
    assign interrupt = irq_q;
    assign args      = args_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q <= WRRESET;
            rstate_q <= RDRESET;
        end else if (ACLK_EN) begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        rstate_d = rstate_q;
        case (wstate_q)
            WRRESET: wstate_d = WRIDLE;
            WRIDLE:  if (s_axi.AWVALID) wstate_d = WRDATA;
            WRDATA:  if (s_axi.WVALID)  wstate_d = WRRESP;
            WRRESP:  if (s_axi.BREADY)  wstate_d = WRIDLE;
            default: wstate_d = WRIDLE;
        endcase
        case (rstate_q)
            RDRESET: rstate_d = RDIDLE;
            RDIDLE:  if (s_axi.ARVALID) rstate_d = RDDATA;
            RDDATA:  if (s_axi.RREADY)  rstate_d = RDIDLE;
            default: rstate_d = RDIDLE;
        endcase
    end

    // Each argument is viewed as a zero-padded 64-bit word: bits at or above
    // ARG_WIDTH fall off on write and read back as 0.
    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_arg
        logic [63:0] m64;
        assign m64 = !w_hs                       ? 64'd0 :
                     (waddr_q == AW'(16 + 8*g)) ? {32'd0, wmask} :
                     (waddr_q == AW'(20 + 8*g)) ? {wmask, 32'd0} : 64'd0;
        assign arg_pad[g] = 64'(args_q[g]);
        assign args_d[g]  = (args_q[g] & ~ARG_WIDTH'(m64)) |
                            ARG_WIDTH'({s_axi.WDATA, s_axi.WDATA} & m64);
    end

    always_comb begin
        rdata_d = '0;
        case (s_axi.ARADDR)
            A_CTRL:  rdata_d = {24'd0, auto_q, 3'd0, ap_ready, ap_idle, done_q, start_q};
            A_GIE:   rdata_d[0] = gie_q;
            A_IER:   rdata_d[1:0] = ier_q;
            A_ISR:   rdata_d[1:0] = isr_q;
            A_RES:   rdata_d = C_S_AXI_DATA_WIDTH'(res_q);
            A_RVLD:  rdata_d[0] = rvld_q;
            default: ;
        endcase
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (s_axi.ARADDR == AW'(16 + 8*i)) rdata_d = arg_pad[i][31:0];
            if (s_axi.ARADDR == AW'(20 + 8*i)) rdata_d = arg_pad[i][63:32];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            waddr_q <= '0;
            rdata_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= 1'b0;
            gie_q   <= 1'b0;
            ier_q   <= '0;
            isr_q   <= '0;
            irq_q   <= 1'b0;
            res_q   <= '0;
            rvld_q  <= 1'b0;
            args_q  <= '0;
        end else if (ACLK_EN) begin
            args_q <= args_d;
            if (aw_hs) waddr_q <= s_axi.AWADDR;
            if (ar_hs) rdata_q <= rdata_d;

            if (wr_ctrl && s_axi.WDATA[0])  start_q <= 1'b1;
            else if (ap_ready && !auto_q)   start_q <= 1'b0;
            if (wr_ctrl) auto_q <= s_axi.WDATA[7];

            // Pulses outrank the clear-on-read so no event is lost.
            if (ap_done)                                   done_q <= 1'b1;
            else if (ar_hs && s_axi.ARADDR == A_CTRL)      done_q <= 1'b0;

            if (w_hs && waddr_q == A_GIE && s_axi.WSTRB[0]) gie_q <= s_axi.WDATA[0];
            if (w_hs && waddr_q == A_IER && s_axi.WSTRB[0]) ier_q <= s_axi.WDATA[1:0];
            for (int n = 0; n < 2; n++) begin
                if (ier_q[n] && (n == 0 ? ap_done : ap_ready)) isr_q[n] <= 1'b1;
                else if (wr_isr) isr_q[n] <= isr_q[n] ^ s_axi.WDATA[n];
            end
            irq_q <= gie_q & (isr_q[0] | isr_q[1]);

            if (res_vld) res_q <= res_data;
            if (res_vld)                                   rvld_q <= 1'b1;
            else if (ar_hs && s_axi.ARADDR == A_RVLD)      rvld_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_poly_ctrl_s_axi.sv
// Directed bench for poly_ctrl_s_axi (NUM_ARGS=3, ARG_WIDTH=48).
module tb_poly_ctrl_s_axi;
    localparam int LIM = 100;

    logic         ACLK = 1'b0;
    logic         ARESETN, ACLK_EN;
    logic         ap_start, ap_done, ap_idle, ap_ready;
    logic [143:0] args;
    logic [31:0]  res_data;
    logic         res_vld, interrupt;
    int           tests = 0;
    int           fails = 0;

    poly_ctrl_s_axi_if #(.ADDR_W(8)) bus ();

    poly_ctrl_s_axi #(
        .C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32),
        .NUM_ARGS(3), .ARG_WIDTH(48), .RES_WIDTH(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ACLK_EN(ACLK_EN), .s_axi(bus),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .args(args), .res_data(res_data), .res_vld(res_vld), .interrupt(interrupt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [7:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int n);
        if (n >= LIM) begin
            tests++;
            fails++;
            $display("FAIL timeout %s: waited %0d cycles", nm, n);
        end
    endtask

    // done_w raises ap_done on the same edge as the W handshake.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit done_w);
        int n;
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < LIM) begin @(posedge ACLK); #1; n++; end
        timeout("aw", n);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
        bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
        n = 0;
        while (!bus.WREADY && n < LIM) begin @(posedge ACLK); #1; n++; end
        timeout("w", n);
        ap_done = done_w;
        @(posedge ACLK); #1;
        bus.WVALID = 1'b0; ap_done = 1'b0; bus.BREADY = 1'b1;
        n = 0;
        while (!bus.BVALID && n < LIM) begin @(posedge ACLK); #1; n++; end
        timeout("b", n);
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
    endtask

    // res_w raises res_vld on the same edge as the AR handshake.
    task automatic axi_read(input logic [7:0] a, input bit res_w, output logic [31:0] d);
        int n;
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < LIM) begin @(posedge ACLK); #1; n++; end
        timeout("ar", n);
        res_vld = res_w;
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0; res_vld = 1'b0;
        n = 0;
        while (!bus.RVALID && n < LIM) begin @(posedge ACLK); #1; n++; end
        timeout("r", n);
        d = bus.RDATA;
        bus.RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic pulse(input bit rdy, input bit dn);
        ap_ready = rdy; ap_done = dn;
        @(posedge ACLK); #1;
        ap_ready = 1'b0; ap_done = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        // {write addr, data, strb, read addr, expected read}
        tbl[0]  = '{8'h10, 32'h12345678, 4'hF, 8'h10, 32'h12345678};
        tbl[1]  = '{8'h14, 32'hFFFFFFFF, 4'hF, 8'h14, 32'h0000FFFF};
        tbl[2]  = '{8'h18, 32'hDEADBEEF, 4'hF, 8'h18, 32'hDEADBEEF};
        tbl[3]  = '{8'h1C, 32'h0000ABCD, 4'h3, 8'h1C, 32'h0000ABCD};
        tbl[4]  = '{8'h20, 32'hAABBCCDD, 4'h5, 8'h20, 32'h00BB00DD};
        tbl[5]  = '{8'h24, 32'h5A5A1234, 4'hC, 8'h24, 32'h00000000};
        tbl[6]  = '{8'h04, 32'h00000001, 4'hF, 8'h04, 32'h00000001};
        tbl[7]  = '{8'h04, 32'h00000000, 4'hF, 8'h04, 32'h00000000};
        tbl[8]  = '{8'h08, 32'h00000003, 4'hF, 8'h08, 32'h00000003};
        tbl[9]  = '{8'h08, 32'h00000000, 4'hF, 8'h08, 32'h00000000};
        tbl[10] = '{8'h30, 32'hFFFFFFFF, 4'hF, 8'h30, 32'h00000000};
        tbl[11] = '{8'h28, 32'h00001234, 4'hF, 8'h28, 32'h00000000};
        tbl[12] = '{8'h00, 32'h00000001, 4'h0, 8'h00, 32'h00000004};

        ARESETN = 1'b0; ACLK_EN = 1'b1;
        ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
        res_data = '0; res_vld = 1'b0;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_arready", bus.ARREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_start", ap_start, 0);
        ARESETN = 1'b1;
        #1;
        chk("awready_pre", bus.AWREADY, 0);
        @(posedge ACLK); #1;
        chk("awready_post", bus.AWREADY, 1);
        chk("arready_post", bus.ARREADY, 1);
        for (int i = 0; i < 6; i++) begin
            axi_read(8'(8'h10 + 4*i), 1'b0, rd);
            chk($sformatf("rst_arg_%0d", i), rd, 0);
        end
        axi_read(8'h00, 1'b0, rd);
        chk("rst_ctrl", rd, 32'h4);

        for (int i = 0; i < 13; i++) begin
            axi_write(tbl[i].wa, tbl[i].wd, tbl[i].ws, 1'b0);
            axi_read(tbl[i].ra, 1'b0, rd);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
        end
        chk("args0", args[47:0], 48'hFFFF12345678);
        chk("args1", args[95:48], 48'hABCDDEADBEEF);
        chk("args2", args[143:96], 48'h000000BB00DD);
        chk("no_start_strb0", ap_start, 0);

        // start / done handshake
        axi_write(8'h00, 32'h1, 4'hF, 1'b0);
        chk("start_set", ap_start, 1);
        pulse(1'b1, 1'b0);
        chk("start_clr", ap_start, 0);
        pulse(1'b0, 1'b1);
        axi_read(8'h00, 1'b0, rd);
        chk("ctrl_done1", rd, 32'h6);
        axi_read(8'h00, 1'b0, rd);
        chk("ctrl_done0", rd, 32'h4);

        // auto-restart
        axi_write(8'h00, 32'h81, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            chk($sformatf("auto_start_%0d", i), ap_start, 1);
        end
        axi_read(8'h00, 1'b0, rd);
        chk("ctrl_auto", rd, 32'h85);
        axi_write(8'h00, 32'h0, 4'hF, 1'b0);
        chk("auto_off_hold", ap_start, 1);
        pulse(1'b1, 1'b0);
        chk("auto_off_clr", ap_start, 0);

        // interrupt
        axi_write(8'h04, 32'h1, 4'hF, 1'b0);
        axi_write(8'h08, 32'h1, 4'hF, 1'b0);
        chk("irq_idle", interrupt, 0);
        pulse(1'b0, 1'b1);
        @(posedge ACLK); #1;
        chk("irq_done", interrupt, 1);
        axi_write(8'h0C, 32'h1, 4'hF, 1'b0);
        chk("irq_toggled", interrupt, 0);
        pulse(1'b0, 1'b1);
        axi_write(8'h0C, 32'h1, 4'hF, 1'b1);
        axi_read(8'h0C, 1'b0, rd);
        chk("isr_event_wins", rd, 32'h1);
        chk("irq_event_wins", interrupt, 1);
        axi_write(8'h0C, 32'h2, 4'hF, 1'b0);
        axi_read(8'h0C, 1'b0, rd);
        chk("isr_toggle_b1", rd, 32'h3);
        axi_write(8'h04, 32'h0, 4'hF, 1'b0);
        @(posedge ACLK); #1;
        chk("irq_gie_off", interrupt, 0);

        // result clear-on-read
        res_data = 32'h55; res_vld = 1'b1;
        @(posedge ACLK); #1;
        res_vld = 1'b0;
        axi_read(8'h28, 1'b0, rd);
        chk("res_data", rd, 32'h55);
        axi_read(8'h2C, 1'b0, rd);
        chk("res_vld_1", rd, 32'h1);
        axi_read(8'h2C, 1'b0, rd);
        chk("res_vld_0", rd, 32'h0);
        res_data = 32'h66;
        axi_read(8'h2C, 1'b1, rd);
        chk("res_vld_sim_rd", rd, 32'h0);
        axi_read(8'h2C, 1'b0, rd);
        chk("res_vld_set_wins", rd, 32'h1);
        axi_read(8'h28, 1'b0, rd);
        chk("res_data2", rd, 32'h66);

        // clock enable freezes state
        axi_write(8'h00, 32'h1, 4'hF, 1'b0);
        ACLK_EN = 1'b0;
        pulse(1'b1, 1'b0);
        chk("en_hold", ap_start, 1);
        ACLK_EN = 1'b1;
        pulse(1'b1, 1'b0);
        chk("en_resume", ap_start, 0);

        // reset mid-read abandons the response
        bus.ARADDR = 8'h10; bus.ARVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0;
        chk("mid_rvalid", bus.RVALID, 1);
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_rvalid", bus.RVALID, 0);
        chk("mid_rst_args", args, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
